// File: rtl/shift_cmp_pkg.sv
// Shared definitions for the shift/compare execution unit.
package shift_cmp_pkg;

  // Operation encodings on in_op; 3'b101..3'b111 are unsupported.
  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_SLTU = 3'b100;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Width of the shift amount field for a given datapath width.
  function automatic int unsigned shamt_width(input int unsigned xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/shift_cmp_stage.sv
// Combinational single-step shifter: moves i_value by up to STEP bits.
module shift_cmp_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 4
) (
  input  logic [XLEN-1:0] i_value,
  input  logic [AW-1:0]   i_amount,
  input  logic            i_left,
  input  logic            i_fill,
  output logic [XLEN-1:0] o_value
);

  logic [2*XLEN-1:0] w_wide;

  // Right shifts pull fill bits in from a replicated upper half.
  assign w_wide = {{XLEN{i_fill}}, i_value} >> i_amount;

  // Select direction.
  always_comb begin
    o_value = i_left ? (i_value << i_amount) : w_wide[XLEN-1:0];
  end

endmodule

// File: rtl/shift_cmp_unit.sv
// Iterative shift / set-less-than unit with valid/ready on both sides.
module shift_cmp_unit
  import shift_cmp_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic            in_w,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);

  localparam int unsigned SW = shamt_width(XLEN);
  localparam int unsigned AW = $clog2(STEP + 1);

  state_e          r_state;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_result;
  logic [SW-1:0]   r_rem;
  logic            r_left;
  logic            r_fill;
  logic            r_wmode;
  logic            r_valid;
  logic            r_illegal;

  logic            w_wmode;
  logic            w_is_shift;
  logic            w_left;
  logic            w_fill;
  logic            w_lt;
  logic [XLEN-1:0] w_src;
  logic [SW-1:0]   w_shamt;
  logic            w_shifting;
  logic [XLEN-1:0] w_cur_val;
  logic [SW-1:0]   w_cur_rem;
  logic            w_cur_left;
  logic            w_cur_fill;
  logic            w_cur_wmode;
  logic [SW-1:0]   w_amt;
  logic [AW-1:0]   w_amt_stg;
  logic [SW-1:0]   w_rem_next;
  logic [XLEN-1:0] w_stg_out;
  logic [XLEN-1:0] w_final;
  logic            w_accept;

  // Decode the incoming op; W-mode operands are pre-extended so the
  // full-width shifter produces a correct low word.
  always_comb begin
    w_wmode    = (XLEN == 64) && in_w;
    w_is_shift = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA);
    w_left     = (in_op == OP_SLL);
    w_src      = in_a;
    if (w_wmode) begin
      for (int i = 32; i < XLEN; i++) begin
        w_src[i] = (in_op == OP_SRA) ? in_a[31] : 1'b0;
      end
    end
    w_fill  = (in_op == OP_SRA) && w_src[XLEN-1];
    w_shamt = in_b[SW-1:0] & (w_wmode ? SW'(31) : {SW{1'b1}});
    w_lt    = (in_op == OP_SLT) ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);
  end

  // The first step is taken on the accept edge, later steps from the accumulator.
  always_comb begin
    w_shifting  = (r_state == StShift);
    w_cur_val   = w_shifting ? r_acc   : w_src;
    w_cur_rem   = w_shifting ? r_rem   : w_shamt;
    w_cur_left  = w_shifting ? r_left  : w_left;
    w_cur_fill  = w_shifting ? r_fill  : w_fill;
    w_cur_wmode = w_shifting ? r_wmode : w_wmode;
    if ({1'b0, w_cur_rem} >= (SW + 1)'(STEP)) begin
      w_amt = SW'(STEP);
    end else begin
      w_amt = w_cur_rem;
    end
    w_amt_stg  = AW'(w_amt);
    w_rem_next = w_cur_rem - w_amt;
  end

  shift_cmp_stage #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_stage (
    .i_value  (w_cur_val),
    .i_amount (w_amt_stg),
    .i_left   (w_cur_left),
    .i_fill   (w_cur_fill),
    .o_value  (w_stg_out)
  );

  // Word-mode results are sign-extended from bit 31.
  always_comb begin
    w_final = w_stg_out;
    if (w_cur_wmode) begin
      for (int i = 32; i < XLEN; i++) begin
        w_final[i] = w_stg_out[31];
      end
    end
  end

  assign in_ready    = !rst && ((r_state == StIdle) || ((r_state == StDone) && out_ready));
  assign w_accept    = in_valid && in_ready && !flush;
  assign out_valid   = r_valid;
  assign out_result  = r_result;
  assign out_illegal = r_illegal;

  // Control FSM and datapath registers; flush outranks everything but reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_illegal <= 1'b0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_left    <= 1'b0;
      r_fill    <= 1'b0;
      r_wmode   <= 1'b0;
    end else if (flush) begin
      r_state <= StIdle;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_wmode <= w_wmode;
      r_left  <= w_left;
      r_fill  <= w_fill;
      if (w_is_shift) begin
        r_illegal <= 1'b0;
        if (w_rem_next == '0) begin
          r_result <= w_final;
          r_valid  <= 1'b1;
          r_state  <= StDone;
        end else begin
          r_acc   <= w_stg_out;
          r_rem   <= w_rem_next;
          r_valid <= 1'b0;
          r_state <= StShift;
        end
      end else if ((in_op == OP_SLT) || (in_op == OP_SLTU)) begin
        r_result  <= XLEN'(w_lt);
        r_illegal <= 1'b0;
        r_valid   <= 1'b1;
        r_state   <= StDone;
      end else begin
        r_result  <= '0;
        r_illegal <= 1'b1;
        r_valid   <= 1'b1;
        r_state   <= StDone;
      end
    end else begin
      unique case (r_state)
        StShift: begin
          r_acc <= w_stg_out;
          r_rem <= w_rem_next;
          if (w_rem_next == '0) begin
            r_result  <= w_final;
            r_illegal <= 1'b0;
            r_valid   <= 1'b1;
            r_state   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/shift_cmp_unit.md
Name: shift_cmp_unit

Overview:
- Parametrised multi-cycle shift/compare execution unit for the RV32I/RV64I core EX stage.
- Handles SLL/SRL/SRA, their immediate forms, SLT/SLTU (immediate compare variants arrive pre-decoded as operand b), and RV64 word-mode (W) shifts.
- Shifts are iterative at a configurable rate (STEP bits per cycle), trading area for latency.
- Valid/ready on both sides so the pipeline can stall; flush input kills in-flight ops on branch or trap.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- STEP, 8, bits shifted per cycle; power of two, 1..XLEN (STEP=XLEN gives single-cycle barrel behaviour).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  kill current op; no result produced.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept an op this cycle.
- in_op  in  3  op code (see package).
- in_w  in  1  word-mode shift; ignored when XLEN=32 and for compares.
- in_a  in  XLEN  rs1 / shift source.
- in_b  in  XLEN  rs2 or sign-extended immediate; shamt = in_b[log2(XLEN)-1:0], or in_b[4:0] when in_w=1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  XLEN  result.
- out_illegal  out  1  op code was unsupported; out_result=0.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, out_valid=0, out_result=0, out_illegal=0. in_ready=0 while rst is high.
- Op codes:
  - 000 SLL, 001 SRL, 010 SRA, 011 SLT (signed), 100 SLTU.
  - 101..111 are illegal: 1-cycle latency, out_illegal=1, out_result=0.
- States:
  - IDLE: waiting for an op.
  - SHIFT: accumulator and remaining count registered.
  - DONE: result held.
- Accept: in_valid && in_ready at posedge T.
  - Compares, illegal ops and shamt=0 go straight to DONE, so out_valid=1 at T+1.
  - Shifts with shamt>0 enter SHIFT; out_valid rises at T+N, where N = ceil(shamt/STEP).
- SHIFT step: each cycle shift by min(STEP, rem) and decrement rem by the same amount. Transition to DONE on the cycle rem reaches 0.
  - SRA fills with the sign of the operand: bit XLEN-1, or bit 31 in W-mode.
- W-mode (XLEN=64 only):
  - Operand is in_a[31:0] and shamt is 5 bits.
  - Result is the 32-bit value sign-extended to 64 bits, including SLLW/SRLW.
- Compares produce {XLEN-1 zeros, lt}. SLT uses signed, SLTU unsigned comparison of the full XLEN.
- Output handshake: out_result/out_illegal are stable while out_valid=1 && out_ready=0.
  - Transfer happens on out_valid && out_ready; the unit then returns to IDLE unless a new op is accepted in the same cycle.
- in_ready = !rst && (state==IDLE || (state==DONE && out_ready)).
  - This allows back-to-back ops with no bubble for 1-cycle ops.
- Flush has priority over everything except rst.
  - At the next posedge: state=IDLE, out_valid=0, and no op is accepted that cycle even if in_valid=1.
  - out_result keeps its last value (don't-care).
- in_* are ignored while in_ready=0 (no latching mid-operation).
- rst asserted mid-SHIFT: unit is in IDLE next cycle, no result emitted.

Decomposition:
- Package shift_cmp_pkg holds:
  - op-code localparams (OP_SLL..OP_SLTU);
  - the state encoding (IDLE/SHIFT/DONE);
  - a helper function for the shamt width, log2(XLEN).
- One sub-module, shift_cmp_stage: combinational single-step shifter.
  - Inputs: value, amount (<=STEP), direction, arith fill bit.
  - Output: the shifted value.
  - Instantiated once inside shift_cmp_unit.

Test Plan:
- XLEN=32, STEP=8, out_ready=1:
  - SLL a=15, b=8 -> out_result=3840 (0x00000F00), out_valid 1 cycle after accept.
  - SRL a=0xF0, b=4 -> 15.
  - SRA a=0x80000000, b=4 -> 0xF8000000 (-134217728).
  - SRA a=-100, b=2 -> -25.
- Latency sweep, STEP=8: SLL a=1365, b=3 -> 10920 after 1 cycle; SLL b=31 -> 0x80000000 after 4 cycles.
  - Repeat with STEP=1 and STEP=32 to confirm N=31 and N=1.
- Compares, back-to-back with no bubble:
  - SLT(-1,1) -> 1; SLT(1,-1) -> 0.
  - SLTU(0xFFFFFFFF,1) -> 0; SLTU(1,0xFFFFFFFF) -> 1.
  - SLT(0,5) -> 1; SLT(7,7) -> 0.
  - Check in_ready held high throughout.
- Backpressure: out_ready=0 for 5 cycles after the result appears.
  - out_result must stay stable and in_ready=0.
  - Result transfers on the first out_ready=1 cycle.
- Flush/reset: flush asserted in cycle 2 of a 4-cycle SLL -> out_valid never rises; next op accepted the following cycle and gives the correct result.
  - Same check with rst in place of flush.
  - Illegal op 111 -> out_illegal=1, out_result=0.
- XLEN=64 W-mode:
  - SLLW a=0x1, b=31 -> 0xFFFFFFFF80000000.
  - SRAW a=0x0000_0000_8000_0000, b=4 -> 0xFFFFFFFFF8000000.
  - SRLW a=0xFFFFFFFF_FFFFFFFF, b=36 (shamt=4) -> 0x000000000FFFFFFF.
